// File: rtl/driver_motor_pwm.sv
// Motor-side H-bridge driver: shared PWM counter, per-channel STOP/DEAD/RUN direction FSM with dead time.
// Optional ramped duty on RUN entry when SOFT_START_EN is defined.
module driver_motor_pwm #(
  parameter int PERIOD    = 1000,
  parameter int DEADTIME  = 50000,
  parameter int RAMP_STEP = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  directie_driverA,
  input  logic [1:0]  directie_driverB,
  input  logic [11:0] factor_dc_driverA,
  input  logic [11:0] factor_dc_driverB,
  output logic        en_a,
  output logic        in1_a,
  output logic        in2_a,
  output logic        en_b,
  output logic        in1_b,
  output logic        in2_b,
  output logic        period_start
);

`ifdef SOFT_START_EN
  localparam bit SOFT_START = 1'b1;
`else
  localparam bit SOFT_START = 1'b0;
`endif

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(PERIOD - 1);
  localparam logic [DW-1:0] DEAD_MAX = DW'(DEADTIME - 1);
  localparam logic [11:0]   DUTY_MAX = 12'(PERIOD);
  // Without soft start a step of a full period lets the duty jump straight to its target.
  localparam logic [11:0]   STEP     = 12'(SOFT_START ? RAMP_STEP : PERIOD);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_DEAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  logic [CW-1:0] cnt_r;
  state_t        state_r    [2];
  state_t        state_s    [2];
  logic [DW-1:0] dead_cnt_r [2];
  logic [DW-1:0] dead_cnt_s [2];
  logic          dir_r      [2];
  logic          dir_s      [2];
  logic [1:0]    cmd_prev_r [2];
  logic [11:0]   duty_eff_r [2];
  logic [1:0]    cmd_s      [2];
  logic [11:0]   factor_s   [2];
  logic          run_entry_s[2];
  logic          pwm_s      [2];

  assign cmd_s[0]    = directie_driverA;
  assign cmd_s[1]    = directie_driverB;
  assign factor_s[0] = factor_dc_driverA;
  assign factor_s[1] = factor_dc_driverB;

  function automatic logic is_go(input logic [1:0] c);
    return (c == 2'b10) || (c == 2'b01);
  endfunction

  function automatic logic [11:0] clamp_duty(input logic [11:0] f);
    return (f >= DUTY_MAX) ? DUTY_MAX : f;
  endfunction

  function automatic logic [11:0] ramp(input logic [11:0] cur, input logic [11:0] tgt);
    if (tgt > cur) begin
      return ((tgt - cur) > STEP) ? (cur + STEP) : tgt;
    end else begin
      return ((cur - tgt) > STEP) ? (cur - STEP) : tgt;
    end
  endfunction

  // Next-state logic of both direction FSMs plus the PWM compare they gate.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_s[i]    = state_r[i];
      dead_cnt_s[i] = dead_cnt_r[i];
      dir_s[i]      = dir_r[i];
      case (state_r[i])
        ST_STOP: begin
          if (is_go(cmd_s[i])) begin
            state_s[i]    = ST_DEAD;
            dead_cnt_s[i] = {DW{1'b0}};
          end else begin
            state_s[i]    = ST_STOP;
          end
        end
        ST_DEAD: begin
          if (cmd_s[i] != cmd_prev_r[i]) begin
            dead_cnt_s[i] = {DW{1'b0}};
          end else if (dead_cnt_r[i] == DEAD_MAX) begin
            dead_cnt_s[i] = {DW{1'b0}};
            if (is_go(cmd_s[i])) begin
              state_s[i] = ST_RUN;
              dir_s[i]   = (cmd_s[i] == 2'b10);
            end else begin
              state_s[i] = ST_STOP;
            end
          end else begin
            dead_cnt_s[i] = dead_cnt_r[i] + DW'(1'b1);
          end
        end
        ST_RUN: begin
          if (!is_go(cmd_s[i])) begin
            state_s[i] = ST_STOP;
          end else if ((cmd_s[i] == 2'b10) != dir_r[i]) begin
            state_s[i]    = ST_DEAD;
            dead_cnt_s[i] = {DW{1'b0}};
          end else begin
            state_s[i] = ST_RUN;
          end
        end
        default: begin
          state_s[i]    = ST_STOP;
          dead_cnt_s[i] = {DW{1'b0}};
          dir_s[i]      = 1'b0;
        end
      endcase
      run_entry_s[i] = (state_s[i] == ST_RUN) && (state_r[i] != ST_RUN);
      // Outputs follow the next state so a stop command clears the pins on the same edge.
      pwm_s[i] = (state_s[i] == ST_RUN) && !(SOFT_START && run_entry_s[i]) &&
                 (12'(cnt_r) < duty_eff_r[i]);
    end
  end

  // Counter, FSM state, duty registers and registered bridge pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= {CW{1'b0}};
      period_start <= 1'b0;
      en_a         <= 1'b0;
      in1_a        <= 1'b0;
      in2_a        <= 1'b0;
      en_b         <= 1'b0;
      in1_b        <= 1'b0;
      in2_b        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        state_r[i]    <= ST_STOP;
        dead_cnt_r[i] <= {DW{1'b0}};
        dir_r[i]      <= 1'b0;
        cmd_prev_r[i] <= 2'b00;
        duty_eff_r[i] <= 12'd0;
      end
    end else begin
      cnt_r        <= (cnt_r == CNT_MAX) ? {CW{1'b0}} : (cnt_r + CW'(1'b1));
      period_start <= (cnt_r == {CW{1'b0}});
      for (int i = 0; i < 2; i++) begin
        state_r[i]    <= state_s[i];
        dead_cnt_r[i] <= dead_cnt_s[i];
        dir_r[i]      <= dir_s[i];
        cmd_prev_r[i] <= cmd_s[i];
        // The factor is sampled on the last count, so the new duty takes effect from count 0.
        if (SOFT_START && run_entry_s[i]) begin
          duty_eff_r[i] <= 12'd0;
        end else if (cnt_r == CNT_MAX) begin
          duty_eff_r[i] <= ramp(duty_eff_r[i], clamp_duty(factor_s[i]));
        end else begin
          duty_eff_r[i] <= duty_eff_r[i];
        end
      end
      en_a  <= pwm_s[0];
      in1_a <= (state_s[0] == ST_RUN) && dir_s[0];
      in2_a <= (state_s[0] == ST_RUN) && !dir_s[0];
      en_b  <= pwm_s[1];
      in1_b <= (state_s[1] == ST_RUN) && dir_s[1];
      in2_b <= (state_s[1] == ST_RUN) && !dir_s[1];
    end
  end

endmodule

// File: tb/tb_driver_motor_pwm.sv
// Directed bench for driver_motor_pwm: per-period high-time scoreboard plus dead-time and pin checks.
// Define SOFT_START_EN for both bench and RTL to exercise the ramped duty.
module tb_driver_motor_pwm;
  localparam int P = 10;
`ifdef SOFT_START_EN
  localparam int RS = 3;
`else
  localparam int RS = P;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  da  = 2'b00;
  logic [1:0]  db  = 2'b00;
  logic [11:0] fa  = 12'd0;
  logic [11:0] fb  = 12'd0;
  logic        en_a, in1_a, in2_a, en_b, in1_b, in2_b, period_start;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int m;

  driver_motor_pwm #(.PERIOD(P), .DEADTIME(4), .RAMP_STEP(3)) dut (
    .clk(clk), .rst(rst),
    .directie_driverA(da), .directie_driverB(db),
    .factor_dc_driverA(fa), .factor_dc_driverB(fb),
    .en_a(en_a), .in1_a(in1_a), .in2_a(in2_a),
    .en_b(en_b), .in1_b(in1_b), .in2_b(in2_b),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected effective duty of the next period, given the previous one and the factor.
  function automatic int nxt(input int cur, input int tgt);
    int t;
    t = (tgt >= P) ? P : tgt;
    if (t > cur + RS) return cur + RS;
    else if (t < cur - RS) return cur - RS;
    else return t;
  endfunction

  task automatic wait_ps();
    int g;
    g = 0;
    while (!period_start && g < 30) begin
      tick();
      g++;
    end
  endtask

  // Counts one full PWM period of high time and compares it with the queued expectation.
  task automatic measure(input bit chb, input int chg_at, input logic [11:0] chg_val, input string tag);
    int c;
    int e;
    wait_ps();
    check({tag, "_sync"}, int'(period_start), 1);
    c = 0;
    for (int k = 0; k < P; k++) begin
      if (k == chg_at) begin
        if (chb) fb = chg_val;
        else     fa = chg_val;
      end
      c += chb ? int'(en_b) : int'(en_a);
      tick();
    end
    check({tag, "_ps"}, int'(period_start), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    check(tag, c, e);
  endtask

  // Counts bridge-off cycles after a command until the wanted pins appear.
  task automatic dead_run(input bit chb, input logic [1:0] want, input string tag);
    int n;
    int g;
    logic [1:0] pins;
    logic en;
    n = 0;
    g = 0;
    pins = 2'b11;
    while (g < 30) begin
      tick();
      g++;
      pins = chb ? {in1_b, in2_b} : {in1_a, in2_a};
      en   = chb ? en_b : en_a;
      if (pins == want) break;
      if (pins == 2'b00 && !en) n++;
      else n += 100;
    end
    check({tag, "_dead"}, n, 4);
    check({tag, "_pins"}, int'(pins), int'(want));
  endtask

  initial begin
    tick(); tick(); tick();
    check("reset_outs", int'({en_a, in1_a, in2_a, en_b, in1_b, in2_b, period_start}), 0);

    // Start both channels: A forward at 5, B reverse at 3.
    rst = 1'b0; da = 2'b10; fa = 12'd5; db = 2'b01; fb = 12'd3;
    dead_run(1'b0, 2'b10, "t1_a");
    check("t1_b_pins", int'({in1_b, in2_b}), 1);
    m = 0;
    m = nxt(m, 5); exp_q.push_back(m);
    m = nxt(m, 5); exp_q.push_back(m);
    measure(1'b0, -1, 12'd0, "t1_win1");
    measure(1'b0, -1, 12'd0, "t1_win2");

    // Over-range factor clamps to 100%, then zero duty.
    fa = 12'h999;
    exp_q.push_back(m);
    m = nxt(m, 12'h999); exp_q.push_back(m);
    m = nxt(m, 12'h999); exp_q.push_back(m);
    for (int i = 0; i < 3; i++) measure(1'b0, -1, 12'd0, "t2_full");
    fa = 12'd0;
    exp_q.push_back(m);
    m = nxt(m, 0); exp_q.push_back(m);
    m = nxt(m, 0); exp_q.push_back(m);
    for (int i = 0; i < 3; i++) measure(1'b0, -1, 12'd0, "t2_zero");

    // Mid-period factor change affects only following periods.
    fa = 12'd5;
    exp_q.push_back(m);
    m = nxt(m, 5); exp_q.push_back(m);
    measure(1'b0, -1, 12'd0, "t4_pre1");
    measure(1'b0, -1, 12'd0, "t4_pre2");
    exp_q.push_back(m);
    measure(1'b0, 2, 12'd8, "t4_mid");
    m = nxt(m, 8); exp_q.push_back(m);
    m = nxt(m, 8); exp_q.push_back(m);
    measure(1'b0, -1, 12'd0, "t4_post1");
    measure(1'b0, -1, 12'd0, "t4_post2");

    // Reversal goes through the dead interval and re-enters RUN.
    da = 2'b01;
    dead_run(1'b0, 2'b01, "t3_rev");
    m = 0;
    m = nxt(m, 8); exp_q.push_back(m);
    m = nxt(m, 8); exp_q.push_back(m);
    measure(1'b0, -1, 12'd0, "t3_win1");
    measure(1'b0, -1, 12'd0, "t3_win2");

    // Stop command on A only; B keeps running.
    da = 2'b11;
    tick();
    check("t5_a_off", int'({en_a, in1_a, in2_a}), 0);
    check("t5_b_pins", int'({in1_b, in2_b}), 1);
    exp_q.push_back(3);
    measure(1'b1, -1, 12'd0, "t5_b_win");
    check("t5_a_still_off", int'({en_a, in1_a, in2_a}), 0);
    da = 2'b10;
    dead_run(1'b0, 2'b10, "t5_a_restart");

    // Reset while running, then a fresh dead interval.
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("t5_rst_outs", int'({en_a, in1_a, in2_a, en_b, in1_b, in2_b, period_start}), 0);
    rst = 1'b0;
    dead_run(1'b0, 2'b10, "t5_after_rst");
    check("t5_b_after_rst", int'({in1_b, in2_b}), 1);

`ifdef SOFT_START_EN
    begin
      int c;
      int g;
      wait_ps();
      da = 2'b11;
      tick(); tick();
      wait_ps();
      fa = 12'd10; da = 2'b10;
      dead_run(1'b0, 2'b10, "t6_entry");
      c = 0;
      g = 0;
      while (!period_start && g < 20) begin
        c += int'(en_a);
        tick();
        g++;
      end
      check("t6_partial", c, 0);
      exp_q.push_back(3); exp_q.push_back(6); exp_q.push_back(9);
      exp_q.push_back(10); exp_q.push_back(10);
      for (int i = 0; i < 5; i++) measure(1'b0, -1, 12'd0, "t6_ramp");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
